fetch_buffer: RTL
=================

# fetch_buffer

Instruction buffer between the instruction-memory response path and the decode stage. Captures each returned {pc, instr} pair into a circular FIFO and presents the oldest entry to decode. Decode back-pressure is absorbed without dropping fetched words. On a speculative redirect (trap, mret, jump, fence) it discards all buffered and same-cycle incoming entries so that only post-redirect instructions reach decode.

## Interface

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- XLEN, 32: width of pc and instruction words.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  redirect or speculation kill from the fetch stage (imem spec); clears the buffer.
- in_valid  in  1  imem response valid this cycle.
- in_pc  in  XLEN  address of the returned instruction.
- in_instr  in  XLEN  returned instruction word.
- in_ready  out  1  buffer can accept a write this cycle; fetch stalls its pc when low.
- out_valid  out  1  head entry is valid.
- out_pc  out  XLEN  pc of the head entry.
- out_instr  out  XLEN  instruction of the head entry.
- out_stall  in  1  decode or execute stall; the head is held while high.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky error flag, set by a write attempt while full.

## Operation

- Storage: DEPTH entries of {pc, instr}, a write pointer (wptr), a read pointer (rptr), and a count register.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH without any special casing.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & ~out_stall & ~flush.
- in_ready = (count != DEPTH). This is a combinational function of registered count only; it does not depend on pop in the same cycle.
- out_valid = (count != 0).
- out_pc and out_instr come from mem[rptr]. When out_valid = 0 they are don't-care, and the bench must not check them.
- Push: mem[wptr] ← {in_pc, in_instr}; wptr ← wptr+1.
- Pop: rptr ← rptr+1.
- Count update: count ← count + push − pop. Simultaneous push and pop leaves count unchanged.
- flush = 1: wptr ← 0, rptr ← 0, count ← 0, and the same-cycle in_valid is dropped. Flush has priority over push and pop.
- Write while full (in_valid & ~in_ready & ~flush): data is dropped, state is unchanged, and overflow ← 1.
- overflow clears only on reset.
- No state machine beyond the occupancy counter. The effective states are EMPTY (count = 0), PARTIAL, and FULL (count = DEPTH).

## Timing

- Reset values: count = 0, wptr = 0, rptr = 0, overflow = 0. After reset, out_valid = 0 and in_ready = 1. Memory contents are not reset.
- Latency: an entry written on edge N is visible at out_* in the cycle after edge N (one-cycle latency). There is no combinational in→out bypass.
- Throughput: one push and one pop per cycle sustained. With out_stall = 0, a continuous in_valid stream never fills the buffer.
- Full with simultaneous pop: in_ready stays 0 for that cycle, so the write is not accepted. Fetch must retry, and in_ready rises the next cycle.
- Flush: takes effect at the next edge. In the flush cycle itself out_valid may still be 1, but pop is suppressed. From the next cycle, out_valid = 0 and in_ready = 1.
- Flush while empty: no effect other than dropping in_valid.
- Reset mid-operation: identical to flush, and additionally clears overflow.
- Reset has priority over flush.
- out_stall has no effect when out_valid = 0.

## Test plan

- Basic pass-through: after reset, push pc 0x0, 0x4, 0x8 with instructions 0x00000013, 0x00100093, 0x00200113 and out_stall = 0. Expect out_valid one cycle after each push, in order, and count returning to 0.
- Fill and back-pressure: hold out_stall = 1 and push 5 entries at DEPTH = 4. Expect in_ready = 0 after the 4th push, the 5th dropped with overflow = 1, and count = 4. Release the stall and expect pcs 0x0–0xC in order, then out_valid = 0.
- Wrap-around: run 10 pushes with pops interleaved 1:1 and stall asserted intermittently. Expect pcs to emerge strictly in order across pointer wrap, with no loss or duplication.
- Flush with traffic: hold 3 entries, then assert flush together with in_valid (pc 0x80). Expect count = 0 and out_valid = 0 next cycle with the 0x80 entry dropped. A subsequent push of pc 0x100 appears at the head one cycle later.
- Simultaneous push and pop at count = 2: expect count to stay 2 and the head to advance to the next older pc.
- Reset mid-operation: with count = 3 and overflow = 1, assert reset for one cycle. Expect count = 0, out_valid = 0, in_ready = 1, and overflow = 0.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular FIFO of {pc, instr} between the
// imem response path and decode, cleared on redirect.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  input  logic                       out_stall,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [2*XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              push, pop;

  assign in_ready  = (cnt_q != FULL_C);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & ~out_stall & ~flush;

  assign out_pc    = mem_q[rptr_q][2*XLEN-1:XLEN];
  assign out_instr = mem_q[rptr_q][XLEN-1:0];
  assign count     = cnt_q;
  assign overflow  = ovf_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (in_valid & ~in_ready & ~flush);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wptr_q] <= {in_pc, in_instr};
  end

endmodule
